icache_refill: RTL and testbench
================================

# icache_refill

Miss-handling engine on the fill side of the 4-way instruction cache. When the cache raises `cache_miss`, it reads the missing 32-bit instruction word from byte-wide backing memory as four little-endian byte beats. It then presents the word on `write_data` with a single-cycle `fetch` strobe, which writes the line into the victim way. It sits between the instruction cache and the external memory bridge, and is the responder to the cache's miss/fetch protocol.

## Interface
- `TIMEOUT_CYCLES`, default 255: consecutive un-acked request cycles in one beat before abort; 0 disables the timeout.
- `CLK`  in  1  sole clock, rising edge.
- `RST_N`  in  1  reset, asynchronous, active-low.
- `cache_miss`  in  1  miss indication from the instruction cache (combinational from its state register).
- `miss_addr`  in  20  byte address of the missed instruction; the core holds it stable while `cache_miss` is high.
- `fetch`  out  1  one-cycle strobe: `write_data` is valid, cache commits the line.
- `write_data`  out  32  assembled instruction word.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  one-cycle strobe coincident with `fetch` when the refill was aborted by timeout.
- `mem_req`  out  1  memory read request.
- `mem_addr`  out  20  byte address of the current beat.
- `mem_ack`  in  1  memory accepted the beat; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  8  read byte.

## Operation
- All outputs are registered. Reset values: `fetch`=0, `err`=0, `busy`=0, `mem_req`=0, `mem_addr`=0, `write_data`=0, state IDLE, beat=0, timeout counter=0.
- States: IDLE, REQ, RESP, HOLD.
- **IDLE.** `cache_miss`=1 sampled at an edge has the following effects:
  - latch `miss_addr[19:2]` (bits 1:0 ignored, word-aligned);
  - set beat=0 and `mem_addr`={latched[19:2],2'b00};
  - set `mem_req`=1 and `busy`=1;
  - go to REQ.
- **REQ.** A beat completes on any edge where `mem_req`=1 and `mem_ack`=1.
  - `mem_rdata` is stored into `write_data[8*beat+7:8*beat]`.
  - The timeout counter clears.
  - For beats 0–2: beat increments, `mem_addr[1:0]` becomes the new beat, and `mem_req` stays 1. Back-to-back acks are legal, one byte per cycle.
  - For beat 3: `mem_req`=0, `fetch`=1, go to RESP.
- **REQ, no ack.** `mem_req` and `mem_addr` are held stable; the timeout counter increments.
- **Timeout.** When the counter reaches `TIMEOUT_CYCLES` (if nonzero):
  - `mem_req`=0, `write_data`=32'h00000000, `fetch`=1, `err`=1;
  - go to RESP.
- **RESP.** `fetch` (and `err`) are high for exactly this one cycle; the cache writes the line and drops `cache_miss` combinationally. Next edge: `fetch`=0, `err`=0, go to HOLD.
- **HOLD.** One cooldown cycle in which `cache_miss` is ignored, so the stale level cannot re-trigger. Next edge: `busy`=0, go to IDLE.
- `mem_ack` while `mem_req`=0 is ignored.
- A `cache_miss` drop during REQ does not abort; the refill completes and `fetch` is still issued.
- `miss_addr` changes after the IDLE capture are ignored.
- `write_data` holds its last value outside RESP and is overwritten beat by beat during the next refill.

## Timing
- Best case with ack in every cycle:
  - miss sampled at edge 0;
  - `mem_req` high in cycles 1–4;
  - beats complete at edges 1–4;
  - `fetch` high in cycle 5;
  - `busy` low from cycle 7;
  - earliest next miss capture at edge 7.
- Refill latency from miss capture to `fetch` is 1 + 4 + (total wait cycles).
- `mem_addr` is stable for the whole of each beat; it changes only on the ack edge.
- Reset mid-refill: all outputs return to reset values asynchronously. The memory side must tolerate an abandoned request. The cache is reset by the same `RST_N`.
- Timeout abort: `fetch` asserts on the cycle after the `TIMEOUT_CYCLES`-th consecutive un-acked REQ cycle in the current beat.

## Test plan
- Miss at `miss_addr`=20'h00104, ack every cycle, bytes 13,00,B0,00 -> `mem_addr` 00104,00105,00106,00107; `write_data`=32'h00B00013; `fetch` one cycle at cycle 5; `err`=0.
- Same address with 3 wait cycles before every ack -> `mem_addr` held stable while waiting; `fetch` at cycle 17; same data.
- `miss_addr`=20'hFFFFF -> beat addresses FFFFC..FFFFF, no carry into bits [19:2].
- `cache_miss` held high through RESP and HOLD (stale level) -> exactly one `fetch`, no second request; a new miss at the first IDLE cycle starts a fresh refill.
- `TIMEOUT_CYCLES`=4, no ack on beat 1 -> `fetch`=`err`=1 on the cycle after the fourth un-acked cycle; `write_data`=0; `mem_req`=0.
- `RST_N` low during beat 2 -> `mem_req`, `busy`, `fetch` immediately 0; no `fetch` after release; a new miss refills normally.

Source files
------------

// File: rtl/icache_refill.sv
// Instruction-cache miss refill engine: fetches one 32-bit word as four
// little-endian byte beats from backing memory and hands it to the cache.
module icache_refill #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        cache_miss,
    input  logic [19:0] miss_addr,
    output logic        fetch,
    output logic [31:0] write_data,
    output logic        busy,
    output logic        err,
    output logic        mem_req,
    output logic [19:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLIM = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, RESP, HOLD} state_t;

    state_t        state, state_n;
    logic [1:0]    beat, beat_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          fetch_n, err_n, busy_n, mem_req_n;
    logic [19:0]   mem_addr_n;
    logic [31:0]   wdata_n;
    logic          timeout_hit;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt == TLIM);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            beat       <= 2'd0;
            tcnt       <= '0;
            fetch      <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= 20'd0;
            write_data <= 32'd0;
        end else begin
            state      <= state_n;
            beat       <= beat_n;
            tcnt       <= tcnt_n;
            fetch      <= fetch_n;
            err        <= err_n;
            busy       <= busy_n;
            mem_req    <= mem_req_n;
            mem_addr   <= mem_addr_n;
            write_data <= wdata_n;
        end
    end

    // mem_addr[19:2] doubles as the latched miss address for the whole refill.
    always_comb begin
        state_n    = state;
        beat_n     = beat;
        tcnt_n     = tcnt;
        fetch_n    = 1'b0;
        err_n      = 1'b0;
        busy_n     = busy;
        mem_req_n  = mem_req;
        mem_addr_n = mem_addr;
        wdata_n    = write_data;
        case (state)
            IDLE: begin
                if (cache_miss) begin
                    beat_n     = 2'd0;
                    tcnt_n     = '0;
                    mem_addr_n = {miss_addr[19:2], 2'b00};
                    mem_req_n  = 1'b1;
                    busy_n     = 1'b1;
                    state_n    = REQ;
                end
            end
            REQ: begin
                if (mem_req && mem_ack) begin
                    wdata_n[{beat, 3'b000} +: 8] = mem_rdata;
                    tcnt_n = '0;
                    if (beat == 2'd3) begin
                        mem_req_n = 1'b0;
                        fetch_n   = 1'b1;
                        state_n   = RESP;
                    end else begin
                        beat_n          = beat + 2'd1;
                        mem_addr_n[1:0] = beat + 2'd1;
                    end
                end else if (timeout_hit) begin
                    tcnt_n    = '0;
                    mem_req_n = 1'b0;
                    wdata_n   = 32'd0;
                    fetch_n   = 1'b1;
                    err_n     = 1'b1;
                    state_n   = RESP;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            RESP: begin
                state_n = HOLD;
            end
            // Cooldown: the stale cache_miss level is ignored here.
            HOLD: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache_refill.sv
// Randomized self-checking bench for icache_refill: a memory/cache model
// drives refills and checks addresses, timing and assembled words.
module tb_icache_refill;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        cache_miss, mem_ack, fetch, err, busy, mem_req;
    logic [19:0] miss_addr, mem_addr;
    logic [7:0]  mem_rdata;
    logic [31:0] write_data;

    logic        t_miss, t_ack, t_fetch, t_err, t_busy, t_mem_req;
    logic [19:0] t_addr, t_mem_addr;
    logic [7:0]  t_rdata;
    logic [31:0] t_wdata;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    icache_refill dut (
        .CLK(CLK), .RST_N(RST_N), .cache_miss(cache_miss), .miss_addr(miss_addr),
        .fetch(fetch), .write_data(write_data), .busy(busy), .err(err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    icache_refill #(.TIMEOUT_CYCLES(4)) dut_to (
        .CLK(CLK), .RST_N(RST_N), .cache_miss(t_miss), .miss_addr(t_addr),
        .fetch(t_fetch), .write_data(t_wdata), .busy(t_busy), .err(t_err),
        .mem_req(t_mem_req), .mem_addr(t_mem_addr), .mem_ack(t_ack), .mem_rdata(t_rdata)
    );

    // Acts as cache and memory for one refill; waits holds 2 bits of wait cycles per beat.
    task automatic run_refill(input logic [19:0] addr, input logic [31:0] word,
                              input logic [7:0] waits, input bit hold_miss, input bit drop_early);
        logic [19:0] exp_a;
        int nw;
        cache_miss = 1'b1;
        miss_addr  = addr;
        mem_ack    = 1'b0;
        @(negedge CLK);
        miss_addr = 20'($urandom);
        if (drop_early) cache_miss = 1'b0;
        for (int b = 0; b < 4; b++) begin
            nw    = int'(waits[2*b +: 2]);
            exp_a = (addr & 20'hFFFFC) + 20'(b);
            for (int w = 0; w <= nw; w++) begin
                checks++;
                if ({mem_req, fetch, err, busy} !== 4'b1001) begin
                    failures++;
                    $display("[TB] FAIL req_phase beat %0d: req/fetch/err/busy got %b want 1001", b, {mem_req, fetch, err, busy});
                end
                checks++;
                if (mem_addr !== exp_a) begin
                    failures++;
                    $display("[TB] FAIL mem_addr beat %0d: got %h want %h", b, mem_addr, exp_a);
                end
                mem_ack   = (w == nw);
                mem_rdata = (w == nw) ? word[8*b +: 8] : 8'($urandom);
                @(negedge CLK);
            end
        end
        mem_ack = 1'b0;
        checks++;
        if ({fetch, err, mem_req, busy} !== 4'b1001 || write_data !== word) begin
            failures++;
            $display("[TB] FAIL fetch_cycle: fetch/err/req/busy got %b want 1001, data got %h want %h",
                     {fetch, err, mem_req, busy}, write_data, word);
        end
        if (!hold_miss) cache_miss = 1'b0;
        @(negedge CLK);
        checks++;
        if ({fetch, err, mem_req, busy} !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL hold_cycle: fetch/err/req/busy got %b want 0001", {fetch, err, mem_req, busy});
        end
        @(negedge CLK);
        checks++;
        if ({fetch, err, mem_req, busy} !== 4'b0000 || write_data !== word) begin
            failures++;
            $display("[TB] FAIL idle_return: fetch/err/req/busy got %b want 0000, data got %h want %h",
                     {fetch, err, mem_req, busy}, write_data, word);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        cache_miss = 1'b0; miss_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
        t_miss = 1'b0; t_addr = '0; t_ack = 1'b0; t_rdata = '0;
        #12;
        checks++;
        if ({fetch, err, busy, mem_req, mem_addr, write_data} !== 56'd0) begin
            failures++;
            $display("[TB] FAIL reset_state: got %h want 0", {fetch, err, busy, mem_req, mem_addr, write_data});
        end
        checks++;
        if ({t_fetch, t_err, t_busy, t_mem_req, t_mem_addr, t_wdata} !== 56'd0) begin
            failures++;
            $display("[TB] FAIL reset_state_to: got %h want 0", {t_fetch, t_err, t_busy, t_mem_req, t_mem_addr, t_wdata});
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_basic();
        run_refill(20'h00104, 32'h00B00013, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_wait_states();
        run_refill(20'h00104, 32'h00B00013, 8'hFF, 1'b0, 1'b0);
    endtask

    task automatic test_addr_top();
        run_refill(20'hFFFFF, $urandom, 8'($urandom), 1'b0, 1'b0);
    endtask

    task automatic test_stale_miss();
        run_refill(20'h0ABC8, 32'hDEADBEEF, 8'h00, 1'b1, 1'b0);
        run_refill(20'h12344, 32'h01234567, 8'h1B, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            run_refill(20'($urandom), $urandom, 8'($urandom), 1'b0, bit'($urandom_range(0, 1)));
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                mem_ack = bit'($urandom_range(0, 1));
                @(negedge CLK);
                checks++;
                if ({fetch, mem_req, busy} !== 3'b000) begin
                    failures++;
                    $display("[TB] FAIL idle_ack_ignored: fetch/req/busy got %b want 000", {fetch, mem_req, busy});
                end
            end
            mem_ack = 1'b0;
        end
    endtask

    task automatic test_timeout();
        logic [31:0] word;
        t_miss = 1'b1; t_addr = 20'h00200; t_ack = 1'b0;
        @(negedge CLK);
        t_miss = 1'b0;
        t_ack = 1'b1; t_rdata = 8'h5A;
        @(negedge CLK);
        t_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({t_mem_req, t_fetch} !== 2'b10 || t_mem_addr !== 20'h00201) begin
                failures++;
                $display("[TB] FAIL timeout_wait %0d: req/fetch got %b addr %h want 10 addr 00201", i, {t_mem_req, t_fetch}, t_mem_addr);
            end
            @(negedge CLK);
        end
        checks++;
        if ({t_fetch, t_err, t_mem_req, t_busy} !== 4'b1101 || t_wdata !== 32'd0) begin
            failures++;
            $display("[TB] FAIL timeout_abort: fetch/err/req/busy got %b want 1101, data got %h want 0",
                     {t_fetch, t_err, t_mem_req, t_busy}, t_wdata);
        end
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if ({t_fetch, t_err, t_busy} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL timeout_idle: fetch/err/busy got %b want 000", {t_fetch, t_err, t_busy});
        end
        // Three waits per beat stays under a limit of four: no abort.
        word = $urandom;
        t_miss = 1'b1; t_addr = 20'h00300;
        @(negedge CLK);
        t_miss = 1'b0;
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < 4; w++) begin
                checks++;
                if ({t_mem_req, t_fetch} !== 2'b10) begin
                    failures++;
                    $display("[TB] FAIL no_timeout beat %0d: req/fetch got %b want 10", b, {t_mem_req, t_fetch});
                end
                t_ack = (w == 3);
                t_rdata = word[8*b +: 8];
                @(negedge CLK);
            end
        end
        t_ack = 1'b0;
        checks++;
        if ({t_fetch, t_err} !== 2'b10 || t_wdata !== word) begin
            failures++;
            $display("[TB] FAIL no_timeout_fetch: fetch/err got %b want 10, data got %h want %h", {t_fetch, t_err}, t_wdata, word);
        end
        @(negedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset_midrefill();
        cache_miss = 1'b1; miss_addr = 20'h00300; mem_ack = 1'b0;
        @(negedge CLK);
        mem_ack = 1'b1; mem_rdata = 8'h11;
        @(negedge CLK);
        mem_rdata = 8'h22;
        @(negedge CLK);
        mem_ack = 1'b0;
        checks++;
        if (mem_addr !== 20'h00302 || mem_req !== 1'b1) begin
            failures++;
            $display("[TB] FAIL beat2_addr: got %h req %b want 00302 req 1", mem_addr, mem_req);
        end
        #2 RST_N = 1'b0;
        cache_miss = 1'b0;
        #1;
        checks++;
        if ({fetch, err, busy, mem_req, mem_addr, write_data} !== 56'd0) begin
            failures++;
            $display("[TB] FAIL async_reset: got %h want 0", {fetch, err, busy, mem_req, mem_addr, write_data});
        end
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem_ack = bit'($urandom_range(0, 1));
            mem_rdata = 8'($urandom);
            @(negedge CLK);
            checks++;
            if ({fetch, mem_req, busy} !== 3'b000) begin
                failures++;
                $display("[TB] FAIL after_reset %0d: fetch/req/busy got %b want 000", i, {fetch, mem_req, busy});
            end
        end
        mem_ack = 1'b0;
        run_refill(20'h00300, 32'hCAFEF00D, 8'($urandom), 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_addr_top();
        test_stale_miss();
        test_random();
        test_timeout();
        test_reset_midrefill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
